// File: rtl/credit_counter_pkg.sv
// Shared widths and default sizing for the credit counter and its release popcount.
package credit_counter_pkg;

    localparam int DEPTH_DEF       = 16;
    localparam int ALLOC_WIDTH_DEF = 4;
    localparam int REL_WIDTH_DEF   = 4;

    localparam int CNT_W     = $clog2(DEPTH_DEF + 1);
    localparam int ALLOC_W   = $clog2(ALLOC_WIDTH_DEF + 1);
    localparam int REL_CNT_W = $clog2(REL_WIDTH_DEF + 1);
    localparam int SUM_W     = $clog2(DEPTH_DEF + ALLOC_WIDTH_DEF + REL_WIDTH_DEF + 1);

    typedef logic [CNT_W-1:0]     credit_cnt_t;
    typedef logic [ALLOC_W-1:0]   alloc_cnt_t;
    typedef logic [REL_CNT_W-1:0] rel_cnt_t;

endpackage

// File: rtl/credit_counter_bit_counter.sv
// Combinational popcount of a lane mask.
module bit_counter
    import credit_counter_pkg::*;
#(
    parameter int DATA_WIDTH = REL_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0]         i_data,
    output logic [$clog2(DATA_WIDTH+1)-1:0] o_count
);

    localparam int OW = $clog2(DATA_WIDTH + 1);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            o_count = o_count + OW'(i_data[i]);
        end
    end

endmodule

// File: rtl/credit_counter.sv
// Free-credit tracker for a DEPTH-slot queue: gated allocation, popcounted releases
// applied one cycle late through rel_pend, sticky overflow detection.
module credit_counter
    import credit_counter_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int ALLOC_WIDTH = ALLOC_WIDTH_DEF,
    parameter int REL_WIDTH   = REL_WIDTH_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic                             alloc_valid_i,
    input  logic [$clog2(ALLOC_WIDTH+1)-1:0] alloc_cnt_i,
    output logic                             alloc_ready_o,
    input  logic [REL_WIDTH-1:0]             release_i,
    output logic [$clog2(DEPTH+1)-1:0]       free_cnt_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic                             overflow_err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(REL_WIDTH + 1);
    localparam int SW = $clog2(DEPTH + ALLOC_WIDTH + REL_WIDTH + 1);

    logic [CW-1:0] r_free_cnt;
    logic [RW-1:0] r_rel_pend;
    logic          r_overflow_err;

    logic [RW-1:0] w_rel_cnt;
    logic [SW-1:0] w_alloc_ext;
    logic [SW-1:0] w_free_ext;
    logic [SW-1:0] w_pend_ext;
    logic [SW-1:0] w_next;
    logic          w_fire;

    bit_counter #(.DATA_WIDTH(REL_WIDTH)) u_rel_popcnt (
        .i_data  (release_i),
        .o_count (w_rel_cnt)
    );

    // Wide sum so an over-release is seen as > DEPTH instead of wrapping.
    always_comb begin
        w_alloc_ext   = SW'(alloc_cnt_i);
        w_free_ext    = SW'(r_free_cnt);
        w_pend_ext    = SW'(r_rel_pend);
        alloc_ready_o = !flush_i
                        && (w_alloc_ext <= SW'(ALLOC_WIDTH))
                        && (w_alloc_ext <= w_free_ext);
        w_fire        = alloc_valid_i && alloc_ready_o;
        w_next        = w_free_ext - (w_fire ? w_alloc_ext : '0) + w_pend_ext;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_free_cnt     <= CW'(DEPTH);
            r_rel_pend     <= '0;
            r_overflow_err <= 1'b0;
        end else if (flush_i) begin
            r_free_cnt <= CW'(DEPTH);
            r_rel_pend <= '0;
        end else begin
            r_rel_pend <= w_rel_cnt;
            if (w_next > SW'(DEPTH)) begin
                r_free_cnt     <= CW'(DEPTH);
                r_overflow_err <= 1'b1;
            end else begin
                r_free_cnt <= w_next[CW-1:0];
            end
        end
    end

    assign free_cnt_o     = r_free_cnt;
    assign full_o         = (r_free_cnt == '0);
    assign empty_o        = (r_free_cnt == CW'(DEPTH)) && (r_rel_pend == '0);
    assign overflow_err_o = r_overflow_err;

endmodule

// File: tb/tb_credit_counter.sv
// Scoreboarded bench for credit_counter: directed scenarios then random traffic.
module tb_credit_counter;
    import credit_counter_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        alloc_valid_i = 1'b0;
    logic [2:0]  alloc_cnt_i = '0;
    logic [3:0]  release_i = '0;
    logic        alloc_ready_o;
    logic [4:0]  free_cnt_o;
    logic        full_o;
    logic        empty_o;
    logic        overflow_err_o;

    credit_counter #(.DEPTH(16), .ALLOC_WIDTH(4), .REL_WIDTH(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .alloc_valid_i  (alloc_valid_i),
        .alloc_cnt_i    (alloc_cnt_i),
        .alloc_ready_o  (alloc_ready_o),
        .release_i      (release_i),
        .free_cnt_o     (free_cnt_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .overflow_err_o (overflow_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rdy;
        int free;
        bit full;
        bit empty;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: free credits, credits waiting one cycle, sticky error.
    int m_free = 0;
    int m_pend = 0;
    bit m_ovf = 0;
    bit m_valid = 0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(input bit fl, input int cnt);
        return !fl && (cnt <= 4) && (cnt <= m_free);
    endfunction

    task automatic step(input bit r, input bit f, input bit v, input int cnt, input logic [3:0] rl);
        exp_t e;
        bit   rdy;
        int   n;
        @(negedge clk);
        rst_i         = r;
        flush_i       = f;
        alloc_valid_i = v;
        alloc_cnt_i   = 3'(cnt);
        release_i     = rl;
        rdy = model_ready(f, cnt);
        if (m_valid) begin
            e.rdy   = rdy;
            e.free  = m_free;
            e.full  = (m_free == 0);
            e.empty = (m_free == DEPTH) && (m_pend == 0);
            e.ovf   = m_ovf;
            exp_q.push_back(e);
        end
        if (r) begin
            m_free = DEPTH; m_pend = 0; m_ovf = 0; m_valid = 1;
        end else if (f) begin
            m_free = DEPTH; m_pend = 0;
        end else begin
            n = m_free - ((v && rdy) ? cnt : 0) + m_pend;
            if (n > DEPTH) begin
                m_free = DEPTH; m_ovf = 1;
            end else begin
                m_free = n;
            end
            m_pend = $countones(rl);
        end
    endtask

    task automatic idle(input int cnt);
        step(0, 0, 0, cnt, 4'b0000);
    endtask

    // Monitor: every cycle the DUT's outputs are compared against the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("sb_ready", int'(alloc_ready_o), int'(e.rdy));
                cmp("sb_free",  int'(free_cnt_o),    e.free);
                cmp("sb_full",  int'(full_o),        int'(e.full));
                cmp("sb_empty", int'(empty_o),       int'(e.empty));
                cmp("sb_ovf",   int'(overflow_err_o), int'(e.ovf));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(1, 0, 0, 0, 4'b0000);
        step(1, 0, 0, 0, 4'b0000);
        idle(0);
        #1;
        cmp("reset_free",  int'(free_cnt_o), 16);
        cmp("reset_empty", int'(empty_o), 1);
        cmp("reset_full",  int'(full_o), 0);
        cmp("reset_ovf",   int'(overflow_err_o), 0);

        for (int i = 0; i < 4; i++) step(0, 0, 1, 4, 4'b0000);
        idle(1);
        #1;
        cmp("drain_free",  int'(free_cnt_o), 0);
        cmp("drain_full",  int'(full_o), 1);
        cmp("drain_ready", int'(alloc_ready_o), 0);

        step(0, 0, 0, 0, 4'b1011);
        idle(0);
        #1;
        cmp("rel_lat1_free", int'(free_cnt_o), 0);
        idle(3);
        #1;
        cmp("rel_free3",  int'(free_cnt_o), 3);
        cmp("rel_ready3", int'(alloc_ready_o), 1);
        idle(4);
        #1;
        cmp("rel_ready4", int'(alloc_ready_o), 0);

        step(0, 0, 0, 0, 4'b1111);
        step(0, 0, 0, 0, 4'b0001);
        step(0, 0, 0, 0, 4'b0111);
        step(0, 0, 1, 2, 4'b0000);
        #1;
        cmp("sim_free8", int'(free_cnt_o), 8);
        idle(0);
        #1;
        cmp("sim_free9", int'(free_cnt_o), 9);

        step(0, 1, 0, 0, 4'b0000);
        idle(0);
        #1;
        cmp("flush_free16", int'(free_cnt_o), 16);
        step(0, 0, 0, 0, 4'b0001);
        idle(0);
        idle(0);
        #1;
        cmp("ovf_free", int'(free_cnt_o), 16);
        cmp("ovf_set",  int'(overflow_err_o), 1);

        step(0, 0, 1, 4, 4'b0000);
        step(0, 0, 1, 4, 4'b0000);
        step(0, 0, 1, 3, 4'b0011);
        step(0, 1, 1, 1, 4'b1111);
        #1;
        cmp("flush_free5",  int'(free_cnt_o), 5);
        cmp("flush_ready",  int'(alloc_ready_o), 0);
        idle(0);
        #1;
        cmp("flush_restore", int'(free_cnt_o), 16);
        cmp("flush_empty",   int'(empty_o), 1);
        idle(0);
        idle(0);
        #1;
        cmp("flush_dropped", int'(free_cnt_o), 16);
        cmp("ovf_sticky",    int'(overflow_err_o), 1);

        for (int i = 0; i < 600; i++) begin
            bit r, f, v;
            int c;
            logic [3:0] rl;
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 3) != 0);
            c  = $urandom_range(0, 7);
            rl = ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(0, 15))) : 4'b0000;
            step(r, f, v, c, rl);
        end
        idle(0);
        @(negedge clk);
        #4;
        cmp("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
